// File: rtl/cpu7_lsu.sv
// cpu7 load/store unit: effective address, one SRAM-like bus transaction, load align/extend.
// Latency: accept->req 1 cycle; writeback 1 cycle after data_ok (3 cycles minimum per op).
// Backpressure: busy while an op is in flight; request held stable until addr_ok; new ops ignored while busy.
module cpu7_lsu #(
    parameter int GRLEN        = 32,
    parameter int LSU_CODE_BIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    ecl_lsu_valid_e,
    input  logic [LSU_CODE_BIT-1:0] ecl_lsu_op_e,
    input  logic [GRLEN-1:0]        ecl_lsu_base_e,
    input  logic [GRLEN-1:0]        ecl_lsu_offset_e,
    input  logic [GRLEN-1:0]        ecl_lsu_wdata_e,
    input  logic [4:0]              ecl_lsu_rd_e,
    input  logic                    ecl_lsu_wen_e,

    output logic                    lsu_ecl_busy,
    output logic [GRLEN-1:0]        lsu_ecl_rdata_m,
    output logic                    lsu_ecl_rdata_valid_m,
    output logic [4:0]              lsu_ecl_rd_m,
    output logic                    lsu_ecl_wen_m,
    output logic                    lsu_ecl_ale_m,
    output logic [GRLEN-1:0]        lsu_ecl_badvaddr_m,

    output logic                    data_req,
    output logic                    data_wr,
    output logic [1:0]              data_size,
    output logic [GRLEN-1:0]        data_addr,
    output logic [3:0]              data_wstrb,
    output logic [GRLEN-1:0]        data_wdata,
    input  logic                    data_addr_ok,
    input  logic                    data_data_ok,
    input  logic [GRLEN-1:0]        data_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    // op field positions
    localparam int OP_STORE = 2;
    localparam int OP_ZEXT  = 3;

    logic [1:0]              r_state;
    logic [LSU_CODE_BIT-1:0] r_op;
    logic [4:0]              r_rd;
    logic                    r_wen;

    logic                    r_wr;
    logic [1:0]              r_size;
    logic [GRLEN-1:0]        r_addr;
    logic [3:0]              r_wstrb;
    logic [GRLEN-1:0]        r_wdata;

    logic [GRLEN-1:0]        r_rdata_m;
    logic                    r_rdata_valid_m;
    logic [4:0]              r_rd_m;
    logic                    r_wen_m;
    logic                    r_ale_m;
    logic [GRLEN-1:0]        r_badvaddr_m;

    logic [GRLEN-1:0]        w_addr;
    logic [1:0]              w_size_in;
    logic [1:0]              w_bus_size;
    logic                    w_store_in;
    logic                    w_misalign;
    logic                    w_accept;
    logic [3:0]              w_wstrb;
    logic [GRLEN-1:0]        w_wdata;
    logic                    w_load_done;
    logic [GRLEN-1:0]        w_shifted;
    logic [GRLEN-1:0]        w_load_data;

    assign w_addr     = ecl_lsu_base_e + ecl_lsu_offset_e;
    assign w_size_in  = ecl_lsu_op_e[1:0];
    assign w_store_in = ecl_lsu_op_e[OP_STORE];
    // reserved size 3 behaves as a word everywhere, including on the bus
    assign w_bus_size = (w_size_in == 2'd3) ? 2'd2 : w_size_in;
    assign w_misalign = ((w_size_in == 2'd1) && w_addr[0]) ||
                        (w_size_in[1] && (w_addr[1:0] != 2'b00));
    assign w_accept   = (r_state == S_IDLE) && ecl_lsu_valid_e;

    // store byte lanes and lane-replicated data; loads assert no lanes
    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = ecl_lsu_wdata_e;
        if (w_store_in) begin
            case (w_size_in)
                2'd0: begin
                    w_wstrb = 4'b0001 << w_addr[1:0];
                    w_wdata = {4{ecl_lsu_wdata_e[7:0]}};
                end
                2'd1: begin
                    w_wstrb = 4'b0011 << w_addr[1:0];
                    w_wdata = {2{ecl_lsu_wdata_e[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = ecl_lsu_wdata_e;
                end
            endcase
        end
    end

    // bus returns the whole word; move the addressed bytes down to bit 0
    assign w_shifted   = data_rdata >> {r_addr[1:0], 3'b000};
    assign w_load_done = (r_state == S_WAIT) && data_data_ok && !r_op[OP_STORE];

    // narrow the shifted word and sign- or zero-extend it
    always_comb begin
        w_load_data = w_shifted;
        case (r_op[1:0])
            2'd0: w_load_data = r_op[OP_ZEXT] ? {{(GRLEN-8){1'b0}}, w_shifted[7:0]}
                                              : {{(GRLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            2'd1: w_load_data = r_op[OP_ZEXT] ? {{(GRLEN-16){1'b0}}, w_shifted[15:0]}
                                              : {{(GRLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    // transaction state: IDLE accepts, REQ holds request until addr_ok, WAIT until data_ok
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept && !w_misalign) r_state <= S_REQ;
                S_REQ:  if (data_addr_ok)           r_state <= S_WAIT;
                S_WAIT: if (data_data_ok)           r_state <= S_IDLE;
                default:                            r_state <= S_IDLE;
            endcase
        end
    end

    // capture the op on accept; held unchanged while busy so the bus request stays stable
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= '0;
            r_rd    <= '0;
            r_wen   <= 1'b0;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= '0;
            r_wstrb <= 4'b0000;
            r_wdata <= '0;
        end else if (w_accept && !w_misalign) begin
            // a misaligned op never reaches the bus, so bus-facing registers keep their old values
            r_op    <= ecl_lsu_op_e;
            r_rd    <= ecl_lsu_rd_e;
            r_wen   <= ecl_lsu_wen_e;
            r_wr    <= w_store_in;
            r_size  <= w_bus_size;
            r_addr  <= w_addr;
            r_wstrb <= w_wstrb;
            r_wdata <= w_wdata;
        end
    end

    // writeback strobe: one cycle after a load's data_ok; stores complete silently
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata_m       <= '0;
            r_rdata_valid_m <= 1'b0;
            r_rd_m          <= '0;
            r_wen_m         <= 1'b0;
        end else begin
            r_rdata_valid_m <= w_load_done;
            r_wen_m         <= w_load_done && r_wen && (r_rd != 5'd0);
            if (w_load_done) begin
                r_rdata_m <= w_load_data;
                r_rd_m    <= r_rd;
            end
        end
    end

    // alignment exception strobe, raised the cycle after a misaligned accept
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ale_m      <= 1'b0;
            r_badvaddr_m <= '0;
        end else begin
            r_ale_m <= w_accept && w_misalign;
            if (w_accept && w_misalign) begin
                r_badvaddr_m <= w_addr;
            end
        end
    end

    assign lsu_ecl_busy          = (r_state != S_IDLE);
    assign lsu_ecl_rdata_m       = r_rdata_m;
    assign lsu_ecl_rdata_valid_m = r_rdata_valid_m;
    assign lsu_ecl_rd_m          = r_rd_m;
    assign lsu_ecl_wen_m         = r_wen_m;
    assign lsu_ecl_ale_m         = r_ale_m;
    assign lsu_ecl_badvaddr_m    = r_badvaddr_m;

    assign data_req   = (r_state == S_REQ);
    assign data_wr    = r_wr;
    assign data_size  = r_size;
    assign data_addr  = r_addr;
    assign data_wstrb = r_wstrb;
    assign data_wdata = r_wdata;

endmodule

// File: tb/tb_cpu7_lsu.sv
// Bench for cpu7_lsu: directed test-plan cases followed by randomized ops against a reference model.
// The bench plays the bus slave with programmable addr_ok / data_ok delays.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_cpu7_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_e;
    logic [3:0]  op_e;
    logic [31:0] base_e, offset_e, wdata_e;
    logic [4:0]  rd_e;
    logic        wen_e;

    logic        busy, rdata_valid_m, wen_m, ale_m;
    logic [31:0] rdata_m, badvaddr_m;
    logic [4:0]  rd_m;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cpu7_lsu #(.GRLEN(32), .LSU_CODE_BIT(4)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .ecl_lsu_valid_e       (valid_e),
        .ecl_lsu_op_e          (op_e),
        .ecl_lsu_base_e        (base_e),
        .ecl_lsu_offset_e      (offset_e),
        .ecl_lsu_wdata_e       (wdata_e),
        .ecl_lsu_rd_e          (rd_e),
        .ecl_lsu_wen_e         (wen_e),
        .lsu_ecl_busy          (busy),
        .lsu_ecl_rdata_m       (rdata_m),
        .lsu_ecl_rdata_valid_m (rdata_valid_m),
        .lsu_ecl_rd_m          (rd_m),
        .lsu_ecl_wen_m         (wen_m),
        .lsu_ecl_ale_m         (ale_m),
        .lsu_ecl_badvaddr_m    (badvaddr_m),
        .data_req              (data_req),
        .data_wr               (data_wr),
        .data_size             (data_size),
        .data_addr             (data_addr),
        .data_wstrb            (data_wstrb),
        .data_wdata            (data_wdata),
        .data_addr_ok          (data_addr_ok),
        .data_data_ok          (data_data_ok),
        .data_rdata            (data_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned m_size(input logic [3:0] op);
        return (op[1:0] == 2'd3) ? 2 : int'(op[1:0]);
    endfunction

    function automatic bit m_misaligned(input logic [3:0] op, input logic [31:0] addr);
        int unsigned n;
        n = 1 << m_size(op);
        return (addr % n) != 0;
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [3:0] op, input logic [31:0] addr);
        int unsigned a;
        a = addr % 4;
        if (!op[2]) return 4'd0;
        case (m_size(op))
            0: return 4'(1 << a);
            1: return 4'(3 << a);
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] wd);
        case (m_size(op))
            0: return (wd % 256) * 32'h0101_0101;
            1: return (wd % 65536) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] word);
        logic [31:0] v;
        v = word / (32'd1 << (8 * (addr % 4)));
        case (m_size(op))
            0: begin
                v = v % 256;
                if (!op[3] && v >= 128) v = v - 256;
            end
            1: begin
                v = v % 65536;
                if (!op[3] && v >= 32768) v = v - 65536;
            end
            default: ;
        endcase
        return v;
    endfunction

    // Issue one op from IDLE and play the bus slave. inject=1 presents a misaligned
    // junk op on valid_e throughout the busy period, which must be ignored.
    task automatic run_op(input logic [3:0] op, input logic [31:0] base, input logic [31:0] off,
                          input logic [31:0] wd, input logic [4:0] rd, input logic wen,
                          input int aw, input int dw, input logic [31:0] word, input bit inject);
        logic [31:0] addr;
        addr = base + off;
        check("idle_busy", busy, 0);
        valid_e = 1; op_e = op; base_e = base; offset_e = off; wdata_e = wd; rd_e = rd; wen_e = wen;
        tick();
        valid_e = 0;
        if (m_misaligned(op, addr)) begin
            check("ale", ale_m, 1);
            check("badvaddr", badvaddr_m, addr);
            check("ale_req", data_req, 0);
            check("ale_busy", busy, 0);
            check("ale_rvalid", rdata_valid_m, 0);
            tick();
            check("ale_pulse", ale_m, 0);
            check("ale_req2", data_req, 0);
            return;
        end
        if (inject) begin
            valid_e = 1; op_e = 4'd2; base_e = 32'h1; offset_e = 32'h0; rd_e = 5'd7; wen_e = 1;
        end
        check("req", data_req, 1);
        check("busy_req", busy, 1);
        check("addr", data_addr, addr);
        check("wr", data_wr, op[2]);
        check("size", data_size, m_size(op));
        check("wstrb", data_wstrb, m_wstrb(op, addr));
        if (op[2]) check("wdata", data_wdata, m_wdata(op, wd));
        for (int i = 0; i < aw; i++) begin
            tick();
            check("hold_req", data_req, 1);
            check("hold_addr", data_addr, addr);
            check("hold_wstrb", data_wstrb, m_wstrb(op, addr));
            check("hold_busy", busy, 1);
            check("hold_ale", ale_m, 0);
        end
        data_addr_ok = 1;
        tick();
        data_addr_ok = 0;
        check("wait_req", data_req, 0);
        check("wait_busy", busy, 1);
        for (int i = 0; i < dw; i++) begin
            tick();
            check("wait_busy2", busy, 1);
            check("wait_rvalid", rdata_valid_m, 0);
        end
        data_data_ok = 1; data_rdata = word;
        tick();
        data_data_ok = 0; data_rdata = $urandom;
        valid_e = 0;
        check("done_busy", busy, 0);
        check("done_ale", ale_m, 0);
        if (!op[2]) begin
            check("rvalid", rdata_valid_m, 1);
            check("rdata", rdata_m, m_load(op, addr, word));
            check("rd_m", rd_m, rd);
            check("wen_m", wen_m, wen && rd != 0);
        end else begin
            check("st_rvalid", rdata_valid_m, 0);
            check("st_wen", wen_m, 0);
        end
        tick();
        check("rvalid_pulse", rdata_valid_m, 0);
        check("post_busy", busy, 0);
        check("post_ale", ale_m, 0);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] rbase;
        reset = 1; valid_e = 0; op_e = 0; base_e = 0; offset_e = 0; wdata_e = 0; rd_e = 0; wen_e = 0;
        data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_req", data_req, 0);
        check("rst_wr", data_wr, 0);
        check("rst_rvalid", rdata_valid_m, 0);
        check("rst_wen", wen_m, 0);
        check("rst_ale", ale_m, 0);
        check("rst_rdata", rdata_m, 0);
        check("rst_rd", rd_m, 0);
        check("rst_badv", badvaddr_m, 0);
        check("rst_addr", data_addr, 0);
        check("rst_wdata", data_wdata, 0);
        check("rst_wstrb", data_wstrb, 0);
        check("rst_size", data_size, 0);
        reset = 0;
        tick();

        // directed test-plan cases
        run_op(4'd2, 32'h1000, 32'h4, 32'h0, 5'd5, 1'b1, 0, 0, 32'hDEADBEEF, 0);
        check("lw_rdata_const", rdata_m, 32'hDEADBEEF);
        run_op(4'd0, 32'h2000, 32'h3, 32'h0, 5'd6, 1'b1, 0, 0, 32'h80123456, 0);
        check("lb_sext_const", rdata_m, 32'hFFFFFF80);
        run_op(4'd8, 32'h2000, 32'h3, 32'h0, 5'd6, 1'b1, 0, 0, 32'h80123456, 0);
        check("lbu_zext_const", rdata_m, 32'h00000080);
        run_op(4'd5, 32'h3000, 32'h2, 32'h1234ABCD, 5'd0, 1'b0, 0, 0, 32'h0, 0);
        run_op(4'd2, 32'h100, 32'h2, 32'h0, 5'd3, 1'b1, 0, 0, 32'h0, 0);
        run_op(4'd1, 32'h400, 32'h2, 32'h0, 5'd0, 1'b1, 3, 2, 32'hCAFE8001, 1);

        // reset while waiting for data_ok
        valid_e = 1; op_e = 4'd2; base_e = 32'h5000; offset_e = 32'h8; rd_e = 5'd9; wen_e = 1;
        tick();
        valid_e = 0; data_addr_ok = 1;
        tick();
        data_addr_ok = 0;
        check("wr_in_wait", busy, 1);
        reset = 1;
        tick();
        reset = 0;
        check("rw_busy", busy, 0);
        check("rw_req", data_req, 0);
        check("rw_addr", data_addr, 0);
        check("rw_size", data_size, 0);
        check("rw_rvalid", rdata_valid_m, 0);
        check("rw_ale", ale_m, 0);
        data_data_ok = 1; data_rdata = 32'h11223344;
        tick();
        data_data_ok = 0;
        check("late_ok_rvalid", rdata_valid_m, 0);
        check("late_ok_busy", busy, 0);
        tick();
        check("late_ok_rvalid2", rdata_valid_m, 0);
        check("late_ok_wen", wen_m, 0);

        // randomized ops
        for (int n = 0; n < 80; n++) begin
            rop   = 4'($urandom_range(0, 15));
            rbase = $urandom;
            if ($urandom_range(0, 2) != 0) rbase[1:0] = 2'b00;
            run_op(rop, rbase, 32'($urandom_range(0, 7)) << (2 * $urandom_range(0, 1)), $urandom,
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom, bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
